// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 7-segment driver for the stopwatch.
// Scans seven digit positions with a blanking gap at the start of each slot,
// snapshots the BCD inputs once per frame, adds decimal points, blanks a
// leading minute zero, shows a dash for invalid BCD and blinks while holding.
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  synchronous active-high reset
//   t_mil_0..t_min_1 in 4 each  BCD time digits
//   s_run    in   1  run status
//   s_hld    in   1  hold (split) status
//   seg      out  7  segments, active-high, seg[0]=a .. seg[6]=g
//   dp       out  1  decimal point, active-high
//   an       out  7  digit enable, one-hot or zero, bit i = digit i
//   led_run  out  1  registered s_run
//   led_hld  out  1  registered s_hld
module stopwatch_display #(
    parameter int unsigned DPN = 5,
    parameter int unsigned GAP = 1,
    parameter int unsigned BPN = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] t_mil_0,
    input  logic [3:0] t_mil_1,
    input  logic [3:0] t_mil_2,
    input  logic [3:0] t_sec_0,
    input  logic [3:0] t_sec_1,
    input  logic [3:0] t_min_0,
    input  logic [3:0] t_min_1,
    input  logic       s_run,
    input  logic       s_hld,
    output logic [6:0] seg,
    output logic       dp,
    output logic [6:0] an,
    output logic       led_run,
    output logic       led_hld
);

    localparam int unsigned CW = (DPN > 1) ? $clog2(DPN) : 1;
    localparam int unsigned BW = (BPN > 1) ? $clog2(BPN) : 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        dig_q, dig_d;
    logic [6:0][3:0]   shadow_q, shadow_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic              phase_q, phase_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [6:0]        an_q, an_d;
    logic              led_run_q, led_hld_q;

    logic              slot_end;
    logic              enable;
    logic [3:0]        digit;

    always_comb begin
        // Scan: slot counter, digit index, per-frame snapshot.
        slot_end = (cnt_q == CW'(DPN - 1));
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        dig_d    = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == 3'd6) ? 3'd0 : dig_q + 3'd1;
        end
        shadow_d = shadow_q;
        if (slot_end && dig_q == 3'd6) begin
            shadow_d = {t_min_1, t_min_0, t_sec_1, t_sec_0, t_mil_2, t_mil_1, t_mil_0};
        end

        // Blink: only advances while holding, otherwise parked at visible.
        bcnt_d  = '0;
        phase_d = 1'b0;
        if (s_hld) begin
            if (bcnt_q == BW'(BPN - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d  = bcnt_q + 1'b1;
                phase_d = phase_q;
            end
        end

        // Outputs from the current state; registered below.
        // Written as +1 > GAP so GAP=0 does not form an always-true compare.
        enable = (32'(cnt_q) + 32'd1 > GAP) && !phase_q;
        digit  = shadow_q[dig_q];
        an_d   = enable ? (7'd1 << dig_q) : 7'd0;
        dp_d   = enable && (dig_q == 3'd3 || dig_q == 3'd5);
        unique case (digit)
            4'd0:    seg_d = 7'b0111111;
            4'd1:    seg_d = 7'b0000110;
            4'd2:    seg_d = 7'b1011011;
            4'd3:    seg_d = 7'b1001111;
            4'd4:    seg_d = 7'b1100110;
            4'd5:    seg_d = 7'b1101101;
            4'd6:    seg_d = 7'b1111101;
            4'd7:    seg_d = 7'b0000111;
            4'd8:    seg_d = 7'b1111111;
            4'd9:    seg_d = 7'b1101111;
            default: seg_d = 7'b1000000;
        endcase
        // Leading minute zero is dark but its anode stays on.
        if (dig_q == 3'd6 && digit == 4'd0) begin
            seg_d = 7'b0000000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            dig_q     <= 3'd0;
            shadow_q  <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            seg_q     <= 7'd0;
            dp_q      <= 1'b0;
            an_q      <= 7'd0;
            led_run_q <= 1'b0;
            led_hld_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            shadow_q  <= shadow_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            led_run_q <= s_run;
            led_hld_q <= s_hld;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign an      = an_q;
    assign led_run = led_run_q;
    assign led_hld = led_hld_q;

endmodule

// File: tb/tb_stopwatch_display.sv
module tb_stopwatch_display;

    logic       clk;
    logic       rst;
    logic [3:0] t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1;
    logic       s_run, s_hld;
    logic [6:0] seg, an;
    logic       dp, led_run, led_hld;
    logic [6:0] g_seg, g_an;
    logic       g_dp, g_led_run, g_led_hld;

    int n_checks = 0;
    int n_fail   = 0;
    int kk;

    stopwatch_display #(.DPN(5), .GAP(1), .BPN(40)) u_dut (
        .clk(clk), .rst(rst),
        .t_mil_0(t_mil_0), .t_mil_1(t_mil_1), .t_mil_2(t_mil_2),
        .t_sec_0(t_sec_0), .t_sec_1(t_sec_1), .t_min_0(t_min_0), .t_min_1(t_min_1),
        .s_run(s_run), .s_hld(s_hld),
        .seg(seg), .dp(dp), .an(an), .led_run(led_run), .led_hld(led_hld)
    );

    // Second instance with no blanking gap.
    stopwatch_display #(.DPN(3), .GAP(0), .BPN(40)) u_gap0 (
        .clk(clk), .rst(rst),
        .t_mil_0(t_mil_0), .t_mil_1(t_mil_1), .t_mil_2(t_mil_2),
        .t_sec_0(t_sec_0), .t_sec_1(t_sec_1), .t_min_0(t_min_0), .t_min_1(t_min_1),
        .s_run(s_run), .s_hld(1'b0),
        .seg(g_seg), .dp(g_dp), .an(g_an), .led_run(g_led_run), .led_hld(g_led_hld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [6:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       led_run;
        logic       chk_seg;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        kk++;
    endtask

    int blanks;
    int vis;

    initial begin
        // edge, an, seg, dp, led_run, chk_seg  (edge counted from reset release)
        vecs.push_back('{1,   7'b0000000, 7'b0000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{2,   7'b0000001, 7'b0111111, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{5,   7'b0000001, 7'b0111111, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{6,   7'b0000000, 7'b0000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{7,   7'b0000010, 7'b0111111, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{12,  7'b0000100, 7'b0111111, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{32,  7'b1000000, 7'b0000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{36,  7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{37,  7'b0000001, 7'b1111101, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{40,  7'b0000001, 7'b1111101, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{42,  7'b0000010, 7'b1101101, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{47,  7'b0000100, 7'b1100110, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{51,  7'b0000000, 7'b0000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{52,  7'b0001000, 7'b1001111, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{55,  7'b0001000, 7'b1001111, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{57,  7'b0010000, 7'b1011011, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{62,  7'b0100000, 7'b0000110, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{67,  7'b1000000, 7'b0000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{70,  7'b1000000, 7'b0000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{72,  7'b0000001, 7'b0000111, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{92,  7'b0010000, 7'b1000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{95,  7'b0010000, 7'b1000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{97,  7'b0100000, 7'b0000110, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{100, 7'b0100000, 7'b0000110, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{132, 7'b0100000, 7'b1101111, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{135, 7'b0100000, 7'b1101111, 1'b1, 1'b1, 1'b1});

        rst = 1'b1;
        s_run = 1'b0;
        s_hld = 1'b0;
        {t_mil_0, t_mil_1, t_mil_2, t_sec_0, t_sec_1, t_min_0, t_min_1} = '0;
        kk = 0;

        // Reset held for three clocks: every output low.
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset%0d outputs", i), {seg, dp, an, led_run, led_hld}, '0);
        end

        rst = 1'b0;
        t_min_1 = 4'd0; t_min_0 = 4'd1; t_sec_1 = 4'd2; t_sec_0 = 4'd3;
        t_mil_2 = 4'd4; t_mil_1 = 4'd5; t_mil_0 = 4'd6;
        kk = 0;
        blanks = 0;

        while (kk < 135) begin
            tick();
            if (g_an == 7'd0) blanks++;
            foreach (vecs[i]) begin
                if (vecs[i].cyc == kk) begin
                    check($sformatf("e%0d an", kk), an, vecs[i].an);
                    check($sformatf("e%0d dp", kk), dp, vecs[i].dp);
                    check($sformatf("e%0d led_run", kk), led_run, vecs[i].led_run);
                    if (vecs[i].chk_seg) check($sformatf("e%0d seg", kk), seg, vecs[i].seg);
                end
            end
            if (kk == 10) s_run = 1'b1;
            // Mid-frame change (digit 2 on screen): must not tear.
            if (kk == 47) begin
                t_mil_0 = 4'd7;
                t_sec_1 = 4'hC;
            end
            // Present exactly at the snapshot edge (edge 105).
            if (kk == 104) t_min_0 = 4'd9;
        end
        check("gap0 blanked slots", blanks, 0);

        // Mid-scan reset while digit 4 is on screen.
        while (kk < 162) tick();
        check("pre-reset an d4", an, 7'b0010000);
        rst = 1'b1;
        tick();
        check("midreset outputs", {seg, dp, an, led_run, led_hld}, '0);
        rst = 1'b0;
        kk = 0;
        tick();
        check("restart e1 an", an, 7'b0000000);
        check("restart e1 led_run", led_run, 1'b1);
        tick();
        check("restart e2 an", an, 7'b0000001);
        check("restart e2 seg", seg, 7'b0111111);
        while (kk < 7) tick();
        check("restart e7 an", an, 7'b0000010);
        check("restart e7 seg", seg, 7'b0111111);
        while (kk < 32) tick();
        check("restart e32 an", an, 7'b1000000);
        check("restart e32 seg", seg, 7'b0000000);

        // Hold blink with BPN=40.
        while (kk < 40) tick();
        check("led_hld before hold", led_hld, 1'b0);
        s_hld = 1'b1;
        tick();
        check("led_hld after rise", led_hld, 1'b1);
        for (int w = 0; w < 3; w++) begin
            vis = (an != 7'd0) ? 1 : 0;
            for (int i = 1; i < 40; i++) begin
                tick();
                if (an != 7'd0) vis++;
            end
            check($sformatf("blink window %0d visible edges", w), vis, (w % 2 == 0) ? 32 : 0);
            tick();
        end
        // Now at the first edge of the fourth window (blank).
        check("blank window 3 start an", an, 7'd0);
        while (kk < 165) tick();
        s_hld = 1'b0;
        vis = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (an != 7'd0) vis++;
        end
        check("an resumes after hold drop", vis > 0, 1'b1);
        check("led_hld after fall", led_hld, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Multiplexed 7-segment display driver for the stopwatch. It consumes the stopwatch's BCD time outputs and its run/hold status flags, and scans seven common-anode digit positions. Each digit is shown for a fixed dwell time with a blanking gap between digits. The driver also adds decimal points, blanks the leading minute zero, flags invalid BCD codes, and blinks the whole display while the hold status is active.

## Interface
- `DPN`, default 5: clock periods per digit slot; must be ≥ `GAP`+1.
- `GAP`, default 1: blanking clocks at the start of each slot (anti-ghosting); 0 allowed.
- `BPN`, default 2500: clock periods per blink half-period while holding.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous, active-high.
- `t_mil_0` … `t_min_1`  in  4 each: BCD digits from the stopwatch (`t_mil_0`, `t_mil_1`, `t_mil_2`, `t_sec_0`, `t_sec_1`, `t_min_0`, `t_min_1`).
- `s_run`  in  1: run status.
- `s_hld`  in  1: hold (split) status.
- `seg`  out  7: segment drive, active-high; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1: decimal point, active-high.
- `an`  out  7: digit enable, one-hot or all-zero, active-high; bit i = digit index i.
- `led_run`  out  1: registered `s_run`.
- `led_hld`  out  1: registered `s_hld`.

## Operation
- **Digit index map:**
  - 0 = `t_mil_0`, 1 = `t_mil_1`, 2 = `t_mil_2`
  - 3 = `t_sec_0`, 4 = `t_sec_1`
  - 5 = `t_min_0`, 6 = `t_min_1`
- **Scan state:** slot counter `cnt` runs 0..`DPN`-1; digit index `d` runs 0..6. `d` increments when `cnt`=`DPN`-1, and 6 wraps to 0. One frame is 7·`DPN` clocks.
- **Snapshot:** all seven BCD inputs are captured into a shadow register on the clock where `cnt`=`DPN`-1 and `d`=6. The displayed values change only at frame boundaries, so a frame never tears.
- **Anode enable:** `an[d]`=1 only when `cnt`≥`GAP` and blink phase = 0; otherwise `an`=0.
- **Decoder (shadow digit `d`):**
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110
  - 5→1101101, 6→1111101, 7→0000111, 8→1111111, 9→1101111 (bit order g..a)
  - Codes 10–15 → 1000000 (dash).
- **Leading zero:** for `d`=6 with a shadow value of 0, `seg`=0 while `an[6]` is still asserted.
- **Decimal point:** `dp`=1 when `d`=3 or `d`=5 and the digit is enabled; otherwise 0.
- **Blink:**
  - While `s_hld`=1, the blink counter counts 0..`BPN`-1 and the phase toggles at wrap.
  - The phase starts at 0, then goes to 1 after `BPN` clocks.
  - While `s_hld`=0, the counter and phase are held at 0.
- **Scan independence:** the scan keeps running regardless of the blink phase or `s_run`.

## Timing
- All outputs are registered and derived from the state of the previous clock (one-cycle latency).
- **Reset values:**
  - Outputs: `seg`=0, `dp`=0, `an`=0, `led_run`=0, `led_hld`=0.
  - Internal state: `cnt`=0, `d`=0, shadow = all zero, blink counter = 0, phase = 0.
- **After the first non-reset edge:**
  - Edge 1: `an`=0 (gap, if `GAP`≥1).
  - Edges `GAP`+1..`DPN`: `an`=0000001, showing the reset shadow (digit 0 → 0111111).
- **Reset mid-operation:** all outputs and state return to reset values at the next edge; the scan restarts at `d`=0.
- **`s_hld` edges:**
  - Rising: `led_hld`=1 at the next edge; the display stays visible for `BPN` clocks, then blanks for `BPN` clocks, and alternates thereafter.
  - Falling during a blank phase: the phase clears at the next edge and `an` resumes within one further cycle in the current slot.
- **Input change on the snapshot clock:** the value present at that edge is captured.
- **`GAP`=0:** `an` is never blanked between slots.

## Test plan
- **Reset:** `rst`=1 for 3 clocks, then 0, with `DPN`=5, `GAP`=1 → all outputs 0 during reset. After release: `an`=0 on edge 1, `an`=0000001 with `seg`=0111111 on edges 2–5, `an`=0000010 on edge 7.
- **Digits:** inputs 0,1,2,3,4,5,6 (min_1..mil_0), wait 2 frames. Expect:
  - `d`=0: `seg`=1111101.
  - `d`=3: `seg`=1001111 with `dp`=1.
  - `d`=5: `seg`=0000110 with `dp`=1.
  - `d`=6: `an[6]`=1 and `seg`=0.
- **Snapshot:** change `t_mil_0` 6→7 while `d`=2 → `d`=0 keeps 1111101 through the end of the frame; the next frame shows 0000111.
- **Invalid BCD:** `t_sec_1`=4'hC → `seg`=1000000 at `d`=4; `dp`=0.
- **Hold blink:** with `BPN`=40, raise `s_hld` → `led_hld`=1 one clock later. Then `an`≠0 during the first 40 clocks, `an`≡0 during the next 40, and so on. Drop `s_hld` during a blank window → `an` resumes within 2 clocks.
- **Mid-scan reset:** assert `rst` for 1 clock at `d`=4 → next edge all outputs 0, and the scan resumes from `d`=0 with zero digits.
